// File: rtl/ulpi_link_ctrl_pkg.sv
// Shared types and constants for the ULPI link controller.
package ulpi_link_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTurn,
    StRx,
    StTxCmd,
    StTxData,
    StStp,
    StAbort
  } ulpi_state_e;

  localparam logic [7:0] TX_CMD_DEFAULT = 8'h40;
  localparam logic [1:0] RXCMD_ACTIVE   = 2'b01;
  localparam logic [1:0] RXCMD_ERROR    = 2'b11;

  // States in which the link owns a transmit (tx_busy is held by these).
  function automatic logic is_tx_state(ulpi_state_e st);
    return (st == StTxCmd) || (st == StTxData) || (st == StStp);
  endfunction

endpackage

// File: rtl/ulpi_link_ctrl_if.sv
// ULPI pin bundle between the link controller and the PHY.
interface ulpi_link_ctrl_if;
  logic       ulpi_clk;
  logic       dir;
  logic       nxt;
  logic [7:0] ulpi_data_in;
  logic [7:0] ulpi_data_out;
  logic       stp;

  modport master (
    input  ulpi_clk,
    input  dir,
    input  nxt,
    input  ulpi_data_in,
    output ulpi_data_out,
    output stp
  );

  modport slave (
    output ulpi_clk,
    output dir,
    output nxt,
    output ulpi_data_in,
    input  ulpi_data_out,
    input  stp
  );
endinterface

// File: rtl/ulpi_link_ctrl_edge_detector.sv
// Rising-edge detector for slow signals oversampled on the system clock.
module ulpi_link_ctrl_edge_detector #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [Width-1:0] sig,
  output logic [Width-1:0] rise
);

  logic [Width-1:0] sig_q;

  // Remember the previous sample of each input.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/ulpi_link_ctrl.sv
// ULPI link-side controller: single-packet transmit with nxt throttling and
// abort on bus turnaround, plus RX CMD / RX data decode.
module ulpi_link_ctrl
  import ulpi_link_ctrl_pkg::*;
#(
  parameter int unsigned TX_BYTES = 66,
  parameter logic [7:0]  TX_CMD   = TX_CMD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  n_rst,
  ulpi_link_ctrl_if.master      ulpi,
  input  logic                  tx_start,
  input  logic [TX_BYTES*8-1:0] tx_payload,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  tx_abort,
  output logic [7:0]            rx_byte,
  output logic                  rx_valid,
  output logic [7:0]            rx_cmd,
  output logic                  rx_cmd_valid,
  output logic                  rx_active,
  output logic                  rx_error
);

  // Kept at least one bit wide so a single-byte packet still has an index.
  localparam int unsigned     IDX_W    = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TX_BYTES - 1);

  ulpi_state_e           state_q, state_d;
  logic [TX_BYTES*8-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic [7:0]            rx_byte_q, rx_byte_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [7:0]            rx_cmd_q, rx_cmd_d;
  logic                  rx_cmd_valid_q, rx_cmd_valid_d;
  logic                  rx_active_q, rx_active_d;
  logic                  rx_error_q, rx_error_d;
  logic                  tx_done_q, tx_done_d;

  logic [1:0] rise;
  logic       tick;
  logic       dir_rise;
  logic [7:0] data_out;
  logic       stp_out;
  logic       abort_out;
  logic       accept;

  ulpi_link_ctrl_edge_detector #(
    .Width (2)
  ) u_edge (
    .clk   (clk),
    .n_rst (n_rst),
    .sig   ({ulpi.dir, ulpi.ulpi_clk}),
    .rise  (rise)
  );

  assign tick     = rise[0];
  assign dir_rise = rise[1];

  assign tx_busy = pending_q | is_tx_state(state_q);
  assign accept  = tx_start & ~tx_busy;

  // Next-state, datapath updates and bus outputs.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    idx_d          = idx_q;
    pending_d      = pending_q;
    rx_byte_d      = rx_byte_q;
    rx_valid_d     = 1'b0;
    rx_cmd_d       = rx_cmd_q;
    rx_cmd_valid_d = 1'b0;
    rx_active_d    = rx_active_q;
    rx_error_d     = rx_error_q;
    tx_done_d      = 1'b0;
    data_out       = 8'h00;
    stp_out        = 1'b0;
    abort_out      = 1'b0;

    if (accept) begin
      pending_d = 1'b1;
      shift_d   = tx_payload;
    end

    case (state_q)
      StIdle: begin
        // PHY taking the bus wins; a pending request waits for the next idle.
        if (dir_rise) begin
          state_d = StTurn;
        end else if (pending_q && tick && !ulpi.dir) begin
          state_d   = StTxCmd;
          pending_d = 1'b0;
        end
      end
      StTurn: begin
        if (tick) begin
          state_d = ulpi.dir ? StRx : StIdle;
        end
      end
      StRx: begin
        if (tick) begin
          if (!ulpi.dir) begin
            state_d     = StTurn;
            rx_active_d = 1'b0;
          end else if (ulpi.nxt) begin
            rx_byte_d  = ulpi.ulpi_data_in;
            rx_valid_d = 1'b1;
          end else begin
            rx_cmd_d       = ulpi.ulpi_data_in;
            rx_cmd_valid_d = 1'b1;
            rx_active_d    = (ulpi.ulpi_data_in[5:4] == RXCMD_ACTIVE);
            rx_error_d     = (ulpi.ulpi_data_in[5:4] == RXCMD_ERROR);
          end
        end
      end
      StTxCmd: begin
        data_out = TX_CMD;
        if (ulpi.dir) begin
          state_d = StAbort;
        end else if (tick && ulpi.nxt) begin
          state_d = StTxData;
          idx_d   = '0;
        end
      end
      StTxData: begin
        data_out = shift_q[7:0];
        if (ulpi.dir) begin
          state_d = StAbort;
        end else if (tick && ulpi.nxt) begin
          if (idx_q == LAST_IDX) begin
            state_d = StStp;
          end else begin
            shift_d = shift_q >> 8;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      StStp: begin
        stp_out = 1'b1;
        if (tick) begin
          state_d   = StIdle;
          tx_done_d = 1'b1;
        end
      end
      StAbort: begin
        abort_out = 1'b1;
        state_d   = StTurn;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= StIdle;
      shift_q        <= '0;
      idx_q          <= '0;
      pending_q      <= 1'b0;
      rx_byte_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      rx_cmd_q       <= 8'h00;
      rx_cmd_valid_q <= 1'b0;
      rx_active_q    <= 1'b0;
      rx_error_q     <= 1'b0;
      tx_done_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      idx_q          <= idx_d;
      pending_q      <= pending_d;
      rx_byte_q      <= rx_byte_d;
      rx_valid_q     <= rx_valid_d;
      rx_cmd_q       <= rx_cmd_d;
      rx_cmd_valid_q <= rx_cmd_valid_d;
      rx_active_q    <= rx_active_d;
      rx_error_q     <= rx_error_d;
      tx_done_q      <= tx_done_d;
    end
  end

  assign ulpi.ulpi_data_out = data_out;
  assign ulpi.stp           = stp_out;
  assign tx_abort           = abort_out;
  assign tx_done            = tx_done_q;
  assign rx_byte            = rx_byte_q;
  assign rx_valid           = rx_valid_q;
  assign rx_cmd             = rx_cmd_q;
  assign rx_cmd_valid       = rx_cmd_valid_q;
  assign rx_active          = rx_active_q;
  assign rx_error           = rx_error_q;

endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// Scoreboard bench for ulpi_link_ctrl with a 4-byte payload.
module tb_ulpi_link_ctrl;

  localparam int unsigned TxBytes = 4;

  typedef enum logic [2:0] {EvBus, EvStp, EvDone, EvAbort, EvCmd, EvData} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [15:0] val;
  } ev_t;

  logic                 clk = 1'b0;
  logic                 n_rst;
  logic                 tx_start;
  logic [TxBytes*8-1:0] tx_payload;
  logic                 tx_busy, tx_done, tx_abort;
  logic [7:0]           rx_byte, rx_cmd;
  logic                 rx_valid, rx_cmd_valid, rx_active, rx_error;

  ev_t  exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic mon_last_u = 1'b0;

  ulpi_link_ctrl_if u_if ();

  ulpi_link_ctrl #(
    .TX_BYTES (TxBytes),
    .TX_CMD   (8'h40)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .ulpi         (u_if),
    .tx_start     (tx_start),
    .tx_payload   (tx_payload),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_abort     (tx_abort),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_cmd       (rx_cmd),
    .rx_cmd_valid (rx_cmd_valid),
    .rx_active    (rx_active),
    .rx_error     (rx_error)
  );

  initial forever #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endfunction

  function automatic void expect_ev(ev_kind_e k, logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Full transmit with nxt always high: TX CMD, payload bytes, stp, done.
  function automatic void expect_tx(logic [31:0] p);
    expect_ev(EvBus, 16'h0040);
    for (int i = 0; i < 4; i++) expect_ev(EvBus, {8'h00, p[i*8 +: 8]});
    expect_ev(EvStp, 16'h0000);
    expect_ev(EvDone, 16'h0000);
  endfunction

  function automatic void observe(ev_kind_e k, logic [15:0] v);
    ev_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got %s/%h, want none", k.name(), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.val == v) n_pass++;
      else $display("FAIL event: got %s/%h, want %s/%h", k.name(), v, e.kind.name(), e.val);
    end
  endfunction

  // One ulpi_clk period (4 clk): PHY-side values change with the rising edge.
  task automatic ucyc(input logic d, input logic n, input logic [7:0] data, input logic start);
    @(negedge clk);
    u_if.dir = d;
    u_if.nxt = n;
    u_if.ulpi_data_in = data;
    u_if.ulpi_clk = 1'b1;
    tx_start = start;
    @(negedge clk);
    tx_start = 1'b0;
    @(negedge clk);
    u_if.ulpi_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_tx(input logic [31:0] p);
    @(negedge clk);
    tx_payload = p;
    tx_start   = 1'b1;
    @(negedge clk);
    tx_start   = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: turns DUT activity into events and scores them against the queue.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (n_rst) begin
        if (u_if.ulpi_clk && !mon_last_u) begin
          if (u_if.stp) observe(EvStp, {8'h00, u_if.ulpi_data_out});
          else if (!u_if.dir && u_if.ulpi_data_out != 8'h00)
            observe(EvBus, {8'h00, u_if.ulpi_data_out});
        end
        if (tx_done)      observe(EvDone, {15'h0, tx_busy});
        if (tx_abort)     observe(EvAbort, {7'h0, tx_busy, u_if.ulpi_data_out});
        if (rx_cmd_valid) observe(EvCmd, {6'h0, rx_error, rx_active, rx_cmd});
        if (rx_valid)     observe(EvData, {8'h00, rx_byte});
      end
      mon_last_u = u_if.ulpi_clk;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] n2;
    n_rst = 1'b0;
    tx_start = 1'b0;
    tx_payload = '0;
    u_if.ulpi_clk = 1'b0;
    u_if.dir = 1'b0;
    u_if.nxt = 1'b0;
    u_if.ulpi_data_in = 8'h00;
    #3;
    check("rst_bus", {23'h0, u_if.stp, u_if.ulpi_data_out}, 32'h0);
    check("rst_tx", {tx_busy, tx_done, tx_abort}, 32'h0);
    check("rst_rx", {rx_valid, rx_cmd_valid, rx_active, rx_error, rx_byte, rx_cmd}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // 1: plain transmit, nxt held high.
    expect_tx(32'hDDCCBBAA);
    start_tx(32'hDDCCBBAA);
    check("t1_busy_after_start", tx_busy, 1);
    for (int i = 0; i < 7; i++) ucyc(1'b0, 1'b1, 8'h00, 1'b0);
    drain("t1_drain");
    check("t1_busy_after_done", tx_busy, 0);

    // 2: nxt low for three ticks on byte BB; a request while busy is ignored.
    n2 = 10'b11_1100_0111;
    expect_ev(EvBus, 16'h0040);
    expect_ev(EvBus, 16'h00AA);
    for (int i = 0; i < 4; i++) expect_ev(EvBus, 16'h00BB);
    expect_ev(EvBus, 16'h00CC);
    expect_ev(EvBus, 16'h00DD);
    expect_ev(EvStp, 16'h0000);
    expect_ev(EvDone, 16'h0000);
    start_tx(32'hDDCCBBAA);
    for (int i = 0; i < 10; i++) begin
      ucyc(1'b0, n2[i], 8'h00, 1'b0);
      if (i == 4) start_tx(32'h11223344);
    end
    drain("t2_drain");
    for (int i = 0; i < 3; i++) ucyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("t2_no_second_tx", tx_busy, 0);

    // 3: PHY takes the bus while CC is on it.
    expect_ev(EvBus, 16'h0040);
    expect_ev(EvBus, 16'h00AA);
    expect_ev(EvBus, 16'h00BB);
    expect_ev(EvAbort, 16'h0000);
    expect_ev(EvCmd, 16'h0021);
    start_tx(32'hDDCCBBAA);
    for (int i = 0; i < 4; i++) ucyc(1'b0, 1'b1, 8'h00, 1'b0);
    ucyc(1'b1, 1'b0, 8'h00, 1'b0);
    ucyc(1'b1, 1'b0, 8'h00, 1'b0);
    ucyc(1'b1, 1'b0, 8'h21, 1'b0);
    ucyc(1'b0, 1'b0, 8'h00, 1'b0);
    ucyc(1'b0, 1'b0, 8'h00, 1'b0);
    drain("t3_drain");
    check("t3_busy_after_abort", tx_busy, 0);

    // 4: receive CMD 10, data 5A, CMD 30, then release.
    expect_ev(EvCmd, 16'h0110);
    expect_ev(EvData, 16'h005A);
    expect_ev(EvCmd, 16'h0230);
    ucyc(1'b1, 1'b0, 8'h00, 1'b0);
    ucyc(1'b1, 1'b0, 8'h00, 1'b0);
    ucyc(1'b1, 1'b0, 8'h10, 1'b0);
    ucyc(1'b1, 1'b1, 8'h5A, 1'b0);
    ucyc(1'b1, 1'b0, 8'h30, 1'b0);
    ucyc(1'b0, 1'b0, 8'h00, 1'b0);
    ucyc(1'b0, 1'b0, 8'h00, 1'b0);
    drain("t4_drain");
    check("t4_error_held", rx_error, 1);
    check("t4_active_cleared", rx_active, 0);
    check("t4_rx_byte", rx_byte, 32'h5A);
    check("t4_rx_cmd", rx_cmd, 32'h30);

    // 5: tx_start together with dir rising; receive first, transmit after release.
    expect_ev(EvCmd, 16'h0110);
    expect_tx(32'hDDCCBBAA);
    tx_payload = 32'hDDCCBBAA;
    ucyc(1'b1, 1'b0, 8'h00, 1'b1);
    check("t5_busy_pending", tx_busy, 1);
    ucyc(1'b1, 1'b0, 8'h00, 1'b0);
    ucyc(1'b1, 1'b0, 8'h10, 1'b0);
    check("t5_busy_in_rx", tx_busy, 1);
    ucyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("t5_active_release", rx_active, 0);
    ucyc(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) ucyc(1'b0, 1'b1, 8'h00, 1'b0);
    drain("t5_drain");
    check("t5_busy_after_done", tx_busy, 0);

    // 6: asynchronous reset mid-payload, then a normal transmit.
    expect_ev(EvBus, 16'h0040);
    expect_ev(EvBus, 16'h0021);
    start_tx(32'h87654321);
    for (int i = 0; i < 3; i++) ucyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("t6_pre_rst_bus", u_if.ulpi_data_out, 32'h43);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("t6_async_rst_bus", {23'h0, u_if.stp, u_if.ulpi_data_out}, 32'h0);
    check("t6_async_rst_tx", {tx_busy, tx_done, tx_abort, rx_error}, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    drain("t6_rst_drain");
    expect_tx(32'hDDCCBBAA);
    start_tx(32'hDDCCBBAA);
    for (int i = 0; i < 7; i++) ucyc(1'b0, 1'b1, 8'h00, 1'b0);
    drain("t6_drain");
    check("t6_busy_after_done", tx_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
